// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO and DATA/STATUS/CTRL registers.
// Optional interrupt output and CTRL.irq_en storage are enabled with `define UART_RX_IRQ_EN.
module uart_rx #(
    parameter int CLK_MHZ    = 12,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata
`ifdef UART_RX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int DIV = (CLK_MHZ * 1000000) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int NW  = PW + 1;

    localparam logic [CW-1:0] FULL_BIT = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(DIV / 2 - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_meta_q, rx_s_q;
    state_t        state_q;
    logic [CW-1:0] baud_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0] count_q;
    logic          overrun_q, frame_err_q;
    logic          overrun_d, frame_err_d;

    // NOTE: every clocked register uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    logic baud_tick, stop_sample, push, frame_set;
    assign baud_tick   = (baud_cnt_q == FULL_BIT);
    assign stop_sample = (state_q == S_STOP) && baud_tick;
    assign push        = stop_sample & rx_s_q;
    assign frame_set   = stop_sample & ~rx_s_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q    <= S_START;
                        baud_cnt_q <= '0;
                    end
                end
                S_START: begin
                    // Mid start bit: a line back high here was a glitch, not a frame.
                    if (baud_cnt_q == HALF_BIT) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        state_q    <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        baud_cnt_q         <= '0;
                        shift_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == 3'd7) state_q <= S_STOP;
                        else                   bit_idx_q <= bit_idx_q + 1'b1;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        baud_cnt_q <= '0;
                        state_q    <= rx_s_q ? S_IDLE : S_BREAK;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic nonempty, full, bus_rd, bus_wr, pop, push_ok, overrun_set, status_wr;
    assign nonempty    = (count_q != '0);
    assign full        = (count_q == DEPTH_N);
    assign bus_rd      = req & ~we;
    assign bus_wr      = req & we & be[0];
    assign pop         = bus_rd & (addr[3:2] == 2'd0) & nonempty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok     = push & (~full | pop);
    assign overrun_set = push & full & ~pop;
    assign status_wr   = bus_wr & (addr[3:2] == 2'd1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; entries are only observed through count_q, which is reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    always_comb begin
        overrun_d   = (overrun_q & ~(status_wr & wdata[3])) | overrun_set;
        frame_err_d = (frame_err_q & ~(status_wr & wdata[2])) | frame_set;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (bus_wr && addr[3:2] == 2'd2) irq_en_q <= wdata[0];
            irq_q <= irq_en_q & (nonempty | overrun_q);
        end
    end

    assign irq = irq_q;
`endif

    // NOTE: rdata gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rdata = '0;
        case (addr[3:2])
            2'd0: rdata = {23'b0, nonempty, nonempty ? mem_q[rd_ptr_q] : 8'h00};
            2'd1: rdata = {28'b0, overrun_q, frame_err_q, full, nonempty};
`ifdef UART_RX_IRQ_EN
            2'd2: rdata = {31'b0, irq_en_q};
`endif
            default: rdata = '0;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{addr[31:4], addr[1:0], wdata[31:4], wdata[1:0], be[3:1]};

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a vector table of frames and register accesses,
// plus hand-timed sequences for same-cycle push/pop when full and reset mid-frame.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DIV = 104;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
`ifdef UART_RX_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL_EXP = 32'h1;
`else
    localparam logic [31:0] CTRL_EXP = 32'h0;
`endif

    uart_rx #(.CLK_MHZ(12), .BAUD(115200), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .resetn(resetn),
        .rx    (rx),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .rdata (rdata)
`ifdef UART_RX_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All bus/line tasks start and end one time unit after a rising edge.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        #2 d = rdata;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
        req = 1'b1; we = 1'b1; addr = a; wdata = wd; be = b;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; be = 4'h0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
    endtask

    task automatic line_low(input int n);
        rx = 1'b0;
        repeat (n) @(posedge clk);
        #1 rx = 1'b1;
        repeat (150) @(posedge clk);
        #1;
    endtask

    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_FRAME, OP_LOW} op_e;
    // For OP_FRAME wdata = {stop, byte}; for OP_LOW wdata = cycles held low.
    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input op_e op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic [31:0] exp, input string name);
        vec_t v;
        v.op = op; v.addr = a; v.wdata = wd; v.be = b; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        add(OP_READ, a, 32'h0, 4'h0, exp, name);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
        add(OP_WRITE, a, wd, b, 32'h0, "");
    endtask

    task automatic fr(input logic [7:0] b, input logic stop);
        add(OP_FRAME, 32'h0, {23'b0, stop, b}, 4'h0, 32'h0, "");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        resetn = 1'b0; rx = 1'b1; req = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; be = '0;

        rd(32'h0, 32'h0, "rst_data");
        rd(32'h4, 32'h0, "rst_status");
        rd(32'h8, 32'h0, "rst_ctrl");
        rd(32'hC, 32'h0, "rst_reg3");
        wr(32'hC, 32'hFFFF_FFFF, 4'hF);
        rd(32'hC, 32'h0, "reg3_wr_ignored");
        wr(32'h8, 32'h1, 4'h1);
        rd(32'h8, CTRL_EXP, "ctrl_rw");
        wr(32'h8, 32'h0, 4'h1);
        rd(32'h8, 32'h0, "ctrl_clr");
        fr(8'hA5, 1'b1);
        rd(32'h4, 32'h1, "a5_status");
        rd(32'h0, 32'h1A5, "a5_data");
        rd(32'h4, 32'h0, "a5_status_after");
        rd(32'h0, 32'h0, "a5_data_empty");
        add(OP_LOW, 32'h0, 32'd20, 4'h0, 32'h0, "");
        rd(32'h4, 32'h0, "glitch_status");
        rd(32'h0, 32'h0, "glitch_data");
        fr(8'h3C, 1'b0);
        add(OP_LOW, 32'h0, 32'd300, 4'h0, 32'h0, "");
        rd(32'h4, 32'h4, "ferr_status");
        wr(32'h4, 32'h8, 4'h1);
        rd(32'h4, 32'h4, "ferr_other_bit");
        wr(32'h4, 32'h4, 4'hE);
        rd(32'h4, 32'h4, "ferr_no_be0");
        wr(32'h4, 32'h4, 4'h1);
        rd(32'h4, 32'h0, "ferr_cleared");
        fr(8'h11, 1'b1);
        rd(32'h0, 32'h111, "after_break_data");
        wr(32'h0, 32'hFFFF_FFFF, 4'hF);
        rd(32'h4, 32'h0, "data_wr_ignored");
        for (int i = 1; i <= 5; i++) fr(8'(i), 1'b1);
        rd(32'h4, 32'hB, "ovr_status");
        rd(32'h0, 32'h101, "ovr_data1");
        rd(32'h0, 32'h102, "ovr_data2");
        rd(32'h0, 32'h103, "ovr_data3");
        rd(32'h0, 32'h104, "ovr_data4");
        rd(32'h0, 32'h0,   "ovr_data5_empty");
        rd(32'h4, 32'h8,   "ovr_sticky");
        wr(32'h4, 32'h8, 4'h1);
        rd(32'h4, 32'h0,   "ovr_cleared");

        repeat (5) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_READ: begin
                    bus_read(vecs[i].addr, d);
                    check(vecs[i].name, d, vecs[i].exp);
                end
                OP_WRITE: bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
                OP_FRAME: send_byte(vecs[i].wdata[7:0], vecs[i].wdata[8]);
                default:  line_low(int'(vecs[i].wdata));
            endcase
        end

        // Full FIFO, then a DATA pop on the very edge the fifth frame's stop bit is sampled.
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        bus_read(32'h4, d);
        check("sim_full_status", d, 32'h3);
        fork
            send_byte(8'h05, 1'b1);
            begin
                repeat (990) @(posedge clk);
                #1;
                bus_read(32'h0, d);
                check("sim_pop_head", d, 32'h101);
            end
        join
        bus_read(32'h4, d);
        check("sim_no_overrun", d, 32'h3);
        for (int i = 2; i <= 5; i++) begin
            bus_read(32'h0, d);
            check("sim_drain", d, 32'h100 | 32'(i));
        end
        bus_read(32'h0, d);
        check("sim_drain_empty", d, 32'h0);

        // Reset during bit 4 of a frame whose remaining bits are all ones.
        send_byte(8'h77, 1'b1);
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (470) @(posedge clk);
                #1 resetn = 1'b0;
                repeat (3) @(posedge clk);
                #1 resetn = 1'b1;
            end
        join
        bus_read(32'h4, d);
        check("rst_mid_status", d, 32'h0);
        bus_read(32'h0, d);
        check("rst_mid_data", d, 32'h0);
`ifdef UART_RX_IRQ_EN
        bus_write(32'h8, 32'h1, 4'h1);
`endif
        send_byte(8'h5A, 1'b1);
`ifdef UART_RX_IRQ_EN
        repeat (2) @(posedge clk);
        #1 check("irq_nonempty", {31'b0, irq}, 32'h1);
`endif
        bus_read(32'h0, d);
        check("rst_fresh_data", d, 32'h15A);
`ifdef UART_RX_IRQ_EN
        repeat (2) @(posedge clk);
        #1 check("irq_drained", {31'b0, irq}, 32'h0);
`endif
        bus_read(32'h4, d);
        check("rst_final_status", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Memory-mapped UART receiver; the receive-side counterpart of the SoC's UART transmitter.
- Samples the asynchronous serial input (8N1, LSB first) and stores completed bytes in a small FIFO.
- Exposes the bytes to the cores as an interconnect slave: req/we/addr/wdata/be in, combinational rdata out; rvalid/gnt are tied high at the top level.

Parameters:
- CLK_MHZ, 12, core clock frequency in MHz.
- BAUD, 115200, line rate. DIV = (CLK_MHZ*1000000)/BAUD, integer-truncated; 104 at the defaults.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- rx  in  1  serial line, asynchronous to clk, idles high.
- req  in  1  slave select from the interconnect.
- we  in  1  1 = write, 0 = read.
- addr  in  32  byte address; only addr[3:2] is decoded.
- wdata  in  32  write data.
- be  in  4  byte enables; only be[0] is honoured.
- rdata  out  32  read data, combinational from addr and current state.
- irq  out  1  present only with UART_RX_IRQ_EN.

Behaviour:
- Reset: asynchronous, active-low.
  - Synchronizer flops reset to 1, FSM to IDLE, bit counter and baud counter to 0.
  - FIFO empty, overrun=0, frame_err=0, irq_en=0.
  - rdata reflects the empty state: DATA reads 0x000, STATUS reads 0x0.
- Input synchronization: rx passes through 2 flops (rx_s); only rx_s is used.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s=0, go to START and clear the baud counter.
  - START: at baud count DIV/2-1 (mid start bit), sample rx_s.
    - rx_s=0: go to DATA, clear the baud counter and the bit index.
    - rx_s=1: treat as a glitch and return to IDLE; nothing is stored.
  - DATA: every DIV cycles, sample rx_s into shift[bit_idx], LSB first. After bit 7, go to STOP.
  - STOP: after DIV cycles, sample rx_s.
    - rx_s=1: push the byte and return to IDLE.
    - rx_s=0: set frame_err, discard the byte, go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. This prevents false starts during a break condition.
- Push timing: a pushed byte is visible (STATUS.nonempty=1) on the cycle after the stop-sample edge.
- FIFO:
  - Circular buffer with read/write pointers and count; pointers wrap modulo FIFO_DEPTH.
  - Push while full, with no pop in the same cycle: byte dropped, overrun set (sticky).
  - Push and pop in the same cycle: both take effect and the count is unchanged, including when full (no overrun).
  - Pop while empty: ignored. A same-cycle push to an empty FIFO is still stored.
- Register map (addr[3:2]):
  - 0, DATA (read): {23'b0, nonempty, head[7:0]}; head reads 0 when empty. A read with req&~we pops at the next posedge if nonempty. Writes are ignored.
  - 1, STATUS (read): {28'b0, overrun, frame_err, full, nonempty}. A write with be[0] clears overrun where wdata[3]=1 and frame_err where wdata[2]=1 (write-1-to-clear). A set event and a clear in the same cycle: the set wins.
  - 2, CTRL: bit0 = irq_en, read/write with be[0]; reads back 0 when the feature is compiled out.
  - 3: reads 0, writes ignored.
- Reset mid-frame: the partial byte is lost. After release, reception restarts only on the next falling edge seen in IDLE.

Optional Feature:
- Macro: UART_RX_IRQ_EN.
- Defined:
  - irq port exists, registered; irq = irq_en & (nonempty | overrun).
  - Suitable for a core irq line next to the watchdog timeout.
- Undefined:
  - No irq port, and no CTRL register storage.
  - Software polls STATUS.

Test Plan:
- CLK_MHZ=12, BAUD=115200 (DIV=104): send 0xA5 with a valid stop bit -> STATUS=0x1; DATA read returns 0x1A5; next STATUS=0x0, next DATA read returns 0x000.
- rx low for 20 cycles, then high -> FSM returns to IDLE; STATUS stays 0x0 and no byte is stored.
- Send 0x3C with stop bit 0, rx held low 300 cycles, then high -> STATUS=0x4, FIFO empty. Write 0x4 to STATUS -> STATUS=0x0. A following frame with 0x11 is received correctly.
- Send 0x01..0x05 back-to-back with no reads -> STATUS=0xB (overrun, full, nonempty). Four DATA reads return 0x101, 0x102, 0x103, 0x104; the 5th read returns 0x000.
- FIFO full, then a DATA read on the same cycle as the 5th stop-sample push -> no overrun, count stays 4, and the last read order ends with 0x105.
- Assert resetn=0 during bit 4 of a frame -> STATUS=0x0, the partial byte is lost, and a fresh 0x5A frame is received as 0x15A. With UART_RX_IRQ_EN and CTRL=1: irq=1 while the FIFO is non-empty and 0 after it is drained.
